hazard_scoreboard: RTL

Parametrised pipeline hazard controller for the TCORE 5-stage pipeline, replacing the purely combinational hazard logic. It keeps EX/DE forwarding and load-use stalling, and adds three things: a register scoreboard for one outstanding non-blocking multi-cycle (MUL/DIV) operation, an exception flush path, and a multi-cycle timeout watchdog. It sits beside the datapath and drives the stall, flush and forward selects of the FE, DE, EX and ME stages.

---
 rtl/hazard_scoreboard.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: EX/DE forwarding, load-use stall, single-entry multi-cycle scoreboard,
// exception flush/kill and timeout watchdog. Define TCORE_HAZARD_PERF_EN to build the stall/flush counters.
module hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AW-1:0]    r1_addr_de_i,
  input  logic [AW-1:0]    r2_addr_de_i,
  input  logic [AW-1:0]    rd_addr_de_i,
  input  logic             rf_rw_de_i,
  input  logic             mc_req_de_i,
  input  logic [AW-1:0]    r1_addr_ex_i,
  input  logic [AW-1:0]    r2_addr_ex_i,
  input  logic [AW-1:0]    rd_addr_ex_i,
  input  logic             load_ex_i,
  input  logic             mc_issue_ex_i,
  input  logic             pc_sel_ex_i,
  input  logic [AW-1:0]    rd_addr_me_i,
  input  logic             rf_rw_me_i,
  input  logic [AW-1:0]    rd_addr_wb_i,
  input  logic             rf_rw_wb_i,
  input  logic             exc_valid_i,
  input  logic             mc_done_i,
  output logic             stall_fe_o,
  output logic             stall_de_o,
  output logic             flush_de_o,
  output logic             flush_ex_o,
  output logic             flush_me_o,
  output logic [1:0]       fwd_a_ex_o,
  output logic [1:0]       fwd_b_ex_o,
  output logic             fwd_a_de_o,
  output logic             fwd_b_de_o,
  output logic             mc_busy_o,
  output logic             mc_kill_o,
  output logic             mc_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int            TW      = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(MC_TIMEOUT - 1);

  logic                busy_q, busy_d;
  logic [AW-1:0]       mc_rd_q, mc_rd_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [TW-1:0]       to_cnt_q, to_cnt_d;

  logic load_use, raw_hit, waw_hit, struct_hit, stall;
  logic redirect, done_ev, timeout_ev;

  function automatic logic [1:0] ex_fwd(input logic [AW-1:0] a, input logic me_w,
                                        input logic [AW-1:0] me_rd, input logic wb_w,
                                        input logic [AW-1:0] wb_rd, input logic mc_hit,
                                        input logic [AW-1:0] mc_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (a != '0) begin
      if (me_w && a == me_rd)      sel = 2'b10;
      else if (wb_w && a == wb_rd) sel = 2'b01;
      else if (mc_hit && a == mc_rd) sel = 2'b11;
    end
    return sel;
  endfunction

  assign fwd_a_ex_o = ex_fwd(r1_addr_ex_i, rf_rw_me_i, rd_addr_me_i, rf_rw_wb_i, rd_addr_wb_i,
                             mc_done_i & busy_q, mc_rd_q);
  assign fwd_b_ex_o = ex_fwd(r2_addr_ex_i, rf_rw_me_i, rd_addr_me_i, rf_rw_wb_i, rd_addr_wb_i,
                             mc_done_i & busy_q, mc_rd_q);
  assign fwd_a_de_o = rf_rw_wb_i && r1_addr_de_i == rd_addr_wb_i && r1_addr_de_i != '0;
  assign fwd_b_de_o = rf_rw_wb_i && r2_addr_de_i == rd_addr_wb_i && r2_addr_de_i != '0;

  // pending_q[0] is never set, but the explicit zero checks keep x0 immune regardless.
  assign load_use   = load_ex_i && rd_addr_ex_i != '0 &&
                      (r1_addr_de_i == rd_addr_ex_i || r2_addr_de_i == rd_addr_ex_i);
  assign raw_hit    = (r1_addr_de_i != '0 && pending_q[r1_addr_de_i]) ||
                      (r2_addr_de_i != '0 && pending_q[r2_addr_de_i]);
  assign waw_hit    = rf_rw_de_i && rd_addr_de_i != '0 && pending_q[rd_addr_de_i];
  assign struct_hit = mc_req_de_i && busy_q;
  assign stall      = load_use | raw_hit | waw_hit | struct_hit;

  assign redirect   = pc_sel_ex_i | exc_valid_i;
  assign stall_fe_o = stall & ~redirect;
  assign stall_de_o = stall & ~redirect;
  assign flush_de_o = redirect;
  assign flush_ex_o = stall | redirect;
  assign flush_me_o = exc_valid_i;

  // Completion beats both kill sources in the same cycle.
  assign done_ev      = mc_done_i & busy_q;
  assign timeout_ev   = busy_q & ~mc_done_i & (to_cnt_q == TO_LAST);
  assign mc_timeout_o = timeout_ev;
  assign mc_kill_o    = busy_q & ~mc_done_i & (exc_valid_i | timeout_ev);
  assign mc_busy_o    = busy_q;

  // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_d    = busy_q;
    mc_rd_d   = mc_rd_q;
    pending_d = pending_q;
    to_cnt_d  = to_cnt_q;
    if (done_ev || mc_kill_o) begin
      busy_d    = 1'b0;
      pending_d = '0;
      to_cnt_d  = '0;
    end else if (busy_q) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
    if (mc_issue_ex_i && !exc_valid_i) begin
      busy_d    = 1'b1;
      mc_rd_d   = rd_addr_ex_i;
      pending_d = '0;
      if (rd_addr_ex_i != '0) pending_d[rd_addr_ex_i] = 1'b1;
      to_cnt_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q    <= 1'b0;
      mc_rd_q   <= '0;
      pending_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      busy_q    <= busy_d;
      mc_rd_q   <= mc_rd_d;
      pending_q <= pending_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

`ifdef TCORE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_de_o && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_de_o && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

  a_no_issue_while_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mc_issue_ex_i && busy_q));

endmodule
